// File: rtl/clk_toggle_gen.sv
// Multi-channel programmable clock divider: each channel generates a square wave,
// a periodic strobe or a one-shot strobe from a divide-by-(div+1) down-counter.

module clk_toggle_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic             i_ena,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_mode,
  output logic             o_tog,
  output logic             o_pls,
  output logic             o_run
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_TOGGLE  = 2'd1;
  localparam logic [1:0] MODE_PULSE   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_mode;
  logic             r_tog;
  logic             r_pls;
  logic             r_run;

  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_mode_nxt;
  logic             w_tog_nxt;
  logic             w_pls_nxt;

  // Next-state: clear beats write, write beats counting (and discards any due event).
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_div_nxt  = r_div;
    w_mode_nxt = r_mode;
    w_tog_nxt  = r_tog;
    w_pls_nxt  = 1'b0;
    if (i_clr) begin
      w_cnt_nxt = r_div;
      w_tog_nxt = 1'b0;
    end else if (i_wr) begin
      w_div_nxt  = i_div;
      w_cnt_nxt  = i_div;
      w_mode_nxt = i_mode;
      w_tog_nxt  = 1'b0;
    end else if (!i_ena) begin
      w_pls_nxt = 1'b0;
    end else if (r_mode == MODE_OFF) begin
      w_tog_nxt = 1'b0;
    end else if (r_cnt != {DIV_W{1'b0}}) begin
      w_cnt_nxt = r_cnt - DIV_W'(1);
    end else begin
      w_cnt_nxt = r_div;
      case (r_mode)
        MODE_TOGGLE:  w_tog_nxt = ~r_tog;
        MODE_PULSE:   w_pls_nxt = 1'b1;
        MODE_ONESHOT: begin
          w_pls_nxt  = 1'b1;
          w_mode_nxt = MODE_OFF;
        end
        default:      w_pls_nxt = 1'b0;
      endcase
    end
  end

  // Channel state registers; running tracks the next mode so a one-shot drops it on its firing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {DIV_W{1'b0}};
      r_div  <= {DIV_W{1'b0}};
      r_mode <= MODE_OFF;
      r_tog  <= 1'b0;
      r_pls  <= 1'b0;
      r_run  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      r_mode <= w_mode_nxt;
      r_tog  <= w_tog_nxt;
      r_pls  <= w_pls_nxt;
      r_run  <= (w_mode_nxt != MODE_OFF);
    end
  end

  assign o_tog = r_tog;
  assign o_pls = r_pls;
  assign o_run = r_run;

endmodule

module clk_toggle_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sync_clr,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] tog_out,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] running
);

  logic                w_sel_ok;
  logic [CHANNELS-1:0] w_wr;

  // Out-of-range selects must not alias onto a real channel.
  assign w_sel_ok = (32'(cfg_sel) < 32'(CHANNELS));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_wr[g] = cfg_we & w_sel_ok & (32'(cfg_sel) == 32'(g));

    clk_toggle_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (sync_clr),
      .i_wr   (w_wr[g]),
      .i_ena  (ena),
      .i_div  (cfg_div),
      .i_mode (cfg_mode),
      .o_tog  (tog_out[g]),
      .o_pls  (pulse_out[g]),
      .o_run  (running[g])
    );
  end

endmodule

// File: tb/tb_clk_toggle_gen.sv
// Directed plus random bench for clk_toggle_gen; the reference model counts enabled
// cycles since each (re)load and derives events, level and strobe arithmetically.

module tb_clk_toggle_gen;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           sync_clr = 1'b0;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_sel = 3'd0;
  logic [7:0]     cfg_div = 8'd0;
  logic [1:0]     cfg_mode = 2'd0;
  logic [NCH-1:0] tog_out;
  logic [NCH-1:0] pulse_out;
  logic [NCH-1:0] running;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: configured div/mode and k = enabled active cycles since last load.
  int         m_k    [NCH];
  int         m_div  [NCH];
  int         m_mode [NCH];
  logic [NCH-1:0] m_pls;

  clk_toggle_gen #(.CHANNELS(NCH), .DIV_W(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sync_clr  (sync_clr),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .tog_out   (tog_out),
    .pulse_out (pulse_out),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_k[c] = 0; m_div[c] = 0; m_mode[c] = 0;
    end
    m_pls = '0;
  endtask

  task automatic model_edge(input logic clr, input logic we, input int sel,
                            input int d, input int m, input logic e);
    m_pls = '0;
    for (int c = 0; c < NCH; c++) begin
      if (clr) begin
        m_k[c] = 0;
      end else if (we && sel == c) begin
        m_div[c] = d; m_mode[c] = m; m_k[c] = 0;
      end else if (e && m_mode[c] != 0) begin
        m_k[c]++;
        if (m_k[c] % (m_div[c] + 1) == 0 && m_mode[c] >= 2) begin
          m_pls[c] = 1'b1;
          if (m_mode[c] == 3) m_mode[c] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] et, er;
    for (int c = 0; c < NCH; c++) begin
      et[c] = (m_mode[c] == 1) && (((m_k[c] / (m_div[c] + 1)) % 2) == 1);
      er[c] = (m_mode[c] != 0);
    end
    check({tag, ".tog"},   32'(tog_out),   32'(et));
    check({tag, ".pulse"}, 32'(pulse_out), 32'(m_pls));
    check({tag, ".run"},   32'(running),   32'(er));
  endtask

  task automatic step(input string tag, input logic clr, input logic we, input int sel,
                      input int d, input int m, input logic e);
    sync_clr = clr; cfg_we = we; cfg_sel = 3'(sel); cfg_div = 8'(d);
    cfg_mode = 2'(m); ena = e;
    @(posedge clk);
    model_edge(clr, we, sel, d, m, e);
    #1;
    check_all(tag);
    sync_clr = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    model_reset();
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.tog", 32'(tog_out), 32'd0);
    check("reset.pulse", 32'(pulse_out), 32'd0);
    check("reset.run", 32'(running), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("idle", 20);

    // Toggle ch0 div=2: flips at T+3, T+6.
    step("tog_wr", 1'b0, 1'b1, 0, 2, 1, 1'b1);
    idle("tog", 3);
    check("tog_t3", 32'(tog_out[0]), 32'd1);
    idle("tog", 3);
    check("tog_t6", 32'(tog_out[0]), 32'd0);
    idle("tog", 3);

    // Pulse ch1 div=3 with a 5-cycle freeze mid-count.
    step("pls_wr", 1'b0, 1'b1, 1, 3, 2, 1'b1);
    idle("pls", 4);
    check("pls_t4", 32'(pulse_out[1]), 32'd1);
    idle("pls", 2);
    for (int i = 0; i < 5; i++) step("freeze", 1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle("pls", 1);
    check("pls_delayed_no", 32'(pulse_out[1]), 32'd0);
    idle("pls", 1);
    check("pls_delayed", 32'(pulse_out[1]), 32'd1);
    idle("pls", 6);

    // One-shot ch2 div=0.
    step("os_wr", 1'b0, 1'b1, 2, 0, 3, 1'b1);
    idle("os", 1);
    check("os_pulse", 32'(pulse_out[2]), 32'd1);
    check("os_run", 32'(running[2]), 32'd0);
    idle("os", 50);

    // Write colliding with ch0 terminal count, then invalid select.
    step("col_wr1", 1'b0, 1'b1, 0, 1, 1, 1'b1);
    idle("col", 1);
    step("col_wr2", 1'b0, 1'b1, 0, 4, 1, 1'b1);
    check("col_noflip", 32'(tog_out[0]), 32'd0);
    idle("col", 4);
    check("col_t4", 32'(tog_out[0]), 32'd0);
    idle("col", 1);
    check("col_t5", 32'(tog_out[0]), 32'd1);
    step("bad_sel", 1'b0, 1'b1, 5, 0, 1, 1'b1);
    idle("bad_sel", 8);

    // Sync clear with a concurrent (ignored) write to ch3.
    step("sc_wr0", 1'b0, 1'b1, 0, 1, 1, 1'b1);
    idle("sc", 1);
    step("sc_wr3", 1'b0, 1'b1, 3, 3, 1, 1'b1);
    idle("sc", 5);
    step("sc_clr", 1'b1, 1'b1, 3, 0, 1, 1'b1);
    check("sc_tog", 32'(tog_out & 4'b1001), 32'd0);
    idle("sc", 2);
    check("sc_ch0_t2", 32'(tog_out[0]), 32'd1);
    idle("sc", 2);
    check("sc_t4", 32'({tog_out[3], tog_out[0]}), 32'd2);
    idle("sc", 8);

    // Asynchronous reset mid-operation.
    step("pre_rst", 1'b0, 1'b1, 1, 0, 2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({tog_out, pulse_out, running}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst", 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
      step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 7)), d, int'($urandom_range(0, 3)),
           ($urandom_range(0, 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
